// File: rtl/plru_set_array_if.sv
// ============================================================================
// Module  : plru_set_array_if
// Brief   : Request/response bundle between the cache controller and the
//           PLRU set array (hit updates, victim lookups, ready).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface plru_set_array_if #(
  parameter int N_WAY  = 16,
  parameter int N_SETS = 64
);
  localparam int WAY_W = $clog2(N_WAY);
  localparam int SET_W = $clog2(N_SETS);

  logic             rdy;
  logic             upd_vld;
  logic [SET_W-1:0] upd_set;
  logic [WAY_W-1:0] upd_way;
  logic             vic_req;
  logic [SET_W-1:0] vic_set;
  logic [N_WAY-1:0] vic_valid;
  logic             vic_vld;
  logic [WAY_W-1:0] vic_way;
  logic             vic_inv;

  modport master (
    input  rdy, vic_vld, vic_way, vic_inv,
    output upd_vld, upd_set, upd_way, vic_req, vic_set, vic_valid
  );

  modport slave (
    output rdy, vic_vld, vic_way, vic_inv,
    input  upd_vld, upd_set, upd_way, vic_req, vic_set, vic_valid
  );
endinterface

`default_nettype wire

// File: rtl/plru_set_array.sv
// ============================================================================
// Module  : plru_set_array
// Brief   : Per-set tree-PLRU storage with invalid-way-first victim select,
//           optional victim auto-touch and a post-reset clearing sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_set_array #(
  parameter int N_WAY     = 16,
  parameter int N_SETS    = 64,
  parameter bit VIC_TOUCH = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  plru_set_array_if.slave   bus
);
  localparam int WAY_W = $clog2(N_WAY);
  localparam int SET_W = $clog2(N_SETS);
  localparam int NODES = N_WAY - 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  generate
    if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0 || N_SETS < 2) begin : g_bad_cfg
      $fatal(1, "plru_set_array: N_WAY must be a power of 2 >= 2 and N_SETS >= 2");
    end
  endgenerate

  // Bit at each node is set to point toward the accessed way.
  function automatic logic [NODES-1:0] f_mark(input logic [NODES-1:0] t,
                                              input logic [WAY_W-1:0] w);
    logic [NODES-1:0] r;
    int               node;
    r    = t;
    node = 0;
    for (int i = WAY_W - 1; i >= 0; i--) begin
      r[node] = w[i];
      node    = 2 * node + 1 + int'(w[i]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] f_walk(input logic [NODES-1:0] t);
    logic [WAY_W-1:0] v;
    int               node;
    v    = '0;
    node = 0;
    for (int i = WAY_W - 1; i >= 0; i--) begin
      v[i] = ~t[node];
      node = 2 * node + 1 + int'(v[i]);
    end
    return v;
  endfunction

  function automatic logic [WAY_W-1:0] f_first_inv(input logic [N_WAY-1:0] valid);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!valid[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [SET_W-1:0] ptr_q, ptr_d;
  logic             vic_vld_q, vic_inv_q;
  logic [WAY_W-1:0] vic_way_q;
  logic [NODES-1:0] tree_q [N_SETS];

  logic             w_rdy;
  logic             w_init_wr;
  logic             w_upd_wr;
  logic             w_vic_acc;
  logic             w_touch_wr;
  logic             w_all_valid;
  logic [NODES-1:0] w_vic_tree;
  logic [WAY_W-1:0] vic_way_d;
  logic             vic_inv_d;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == SET_W'(N_SETS - 1)) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    w_rdy     = 1'b0;
    w_init_wr = 1'b0;
    case (state_q)
      ST_INIT: w_init_wr = 1'b1;
      ST_RUN:  w_rdy     = 1'b1;
      default: w_rdy     = 1'b0;
    endcase
  end

  always_comb begin
    w_vic_tree  = tree_q[bus.vic_set];
    w_all_valid = &bus.vic_valid;
    w_upd_wr    = w_rdy && bus.upd_vld;
    w_vic_acc   = w_rdy && bus.vic_req;
    vic_inv_d   = !w_all_valid;
    vic_way_d   = w_all_valid ? f_walk(w_vic_tree) : f_first_inv(bus.vic_valid);
    // A same-set update wins over the victim touch.
    w_touch_wr  = VIC_TOUCH && w_vic_acc && !(w_upd_wr && bus.upd_set == bus.vic_set);
  end

  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      tree_q[ptr_q] <= '0;
    end else begin
      if (w_upd_wr)   tree_q[bus.upd_set] <= f_mark(tree_q[bus.upd_set], bus.upd_way);
      if (w_touch_wr) tree_q[bus.vic_set] <= f_mark(w_vic_tree, vic_way_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vic_vld_q <= 1'b0;
      vic_way_q <= '0;
      vic_inv_q <= 1'b0;
    end else begin
      vic_vld_q <= w_vic_acc;
      if (w_vic_acc) begin
        vic_way_q <= vic_way_d;
        vic_inv_q <= vic_inv_d;
      end
    end
  end

  assign bus.rdy     = w_rdy;
  assign bus.vic_vld = vic_vld_q;
  assign bus.vic_way = vic_way_q;
  assign bus.vic_inv = vic_inv_q;

endmodule

`default_nettype wire
